// File: rtl/seq_detect_param_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_detect_param_pkg;

  // Default window/pattern width and match counter width
  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  // Detector FSM encoding (1-bit)
  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

endpackage : seq_detect_param_pkg

// File: rtl/seq_detect_param_window.sv
// seq_window: PAT_W-bit shift window plus a saturating fill counter.
// win_nxt/full_nxt show what the window and fill status become if the
// current bit is shifted in on this edge.
module seq_window
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             flush,
  input  logic             din,
  output logic [PAT_W-1:0] win_nxt,
  output logic             full_nxt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_win;
  logic [FILL_W-1:0] r_fill;

  // Look-ahead window and "full including this bit" flag
  always_comb begin
    win_nxt  = {r_win[PAT_W-2:0], din};
    full_nxt = (r_fill >= FILL_W'(PAT_W - 1));
  end

  // Window and fill counter; flush restarts the fill but keeps window content
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (shift) begin
      r_win <= win_nxt;
      if (flush) begin
        r_fill <= '0;
      end else if (r_fill != FILL_W'(PAT_W)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule : seq_window

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with runtime pattern, don't-care
// mask and overlap/non-overlap selection. Emits a registered one-cycle
// find_ok pulse per match.
// Build option: define SEQ_MATCH_CNT_EN to build the saturating match counter;
// otherwise match_cnt is tied to zero.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             din_valid,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [PAT_W-1:0] care_mask,
  input  logic             overlap_en,
  output logic             find_ok,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_rst;
  logic [PAT_W-1:0] w_win_nxt;
  logic             w_full_nxt;
  logic             w_match;
  logic             w_flush;
  logic             r_find_ok;

  assign w_rst = rst | clear;

  seq_window #(
    .PAT_W (PAT_W)
  ) u_window (
    .clk      (clk),
    .rst      (w_rst),
    .shift    (din_valid),
    .flush    (w_flush),
    .din      (din),
    .win_nxt  (w_win_nxt),
    .full_nxt (w_full_nxt)
  );

  // Masked compare on accepted bits once the window is full
  always_comb begin
    w_match = din_valid && w_full_nxt &&
              (((w_win_nxt ^ pattern) & care_mask) == '0);
  end

  // Next-state logic; a non-overlapping match restarts the fill
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    if (w_match && !overlap_en) begin
      w_flush = 1'b1;
    end
    unique case (r_state)
      S_FILL: begin
        if (din_valid && w_full_nxt && !w_flush) begin
          w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (w_flush) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered match pulse
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_find_ok <= 1'b0;
    end else begin
      r_find_ok <= w_match;
    end
  end

  assign find_ok = r_find_ok;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Saturating match counter, steps on the same edge that raises find_ok
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_match_cnt <= '0;
    end else if (w_match && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_match_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule : seq_detect_param
